// File: rtl/fbsa_pkg.sv
// fbsa_pkg: shared widths, FSM encoding and control-gpio bit map for the serial adder
package fbsa_pkg;
    localparam int FBSA_WIDTH     = 4;
    localparam int FBSA_A_WIDTH   = FBSA_WIDTH;
    localparam int FBSA_B_WIDTH   = FBSA_WIDTH;
    localparam int FBSA_SUM_WIDTH = FBSA_WIDTH;
    localparam int FBSA_C_IN  = 0;
    localparam int FBSA_C_OUT = 1;
    localparam int FBSA_START = 2;
    localparam int FBSA_BUSY  = 3;
    localparam int FBSA_DONE  = 4;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} fbsa_state_t;
endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit: one-bit combinational full adder
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/four_bit_serial_full_adder.sv
// four_bit_serial_full_adder: LSB-first bit-serial A + B + C_in with start/done handshake
module four_bit_serial_full_adder
    import fbsa_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [FBSA_A_WIDTH-1:0]   A,
    input  logic [FBSA_B_WIDTH-1:0]   B,
    input  logic                      C_in,
    input  logic                      start,
    output logic [FBSA_SUM_WIDTH-1:0] sum,
    output logic                      C_out,
    output logic                      busy,
    output logic                      done
);
    fbsa_state_t               state_q;
    logic [FBSA_A_WIDTH-1:0]   a_q;
    logic [FBSA_B_WIDTH-1:0]   b_q;
    logic                      carry_q;
    logic [1:0]                cnt_q;
    logic [FBSA_SUM_WIDTH-1:0] sum_q;
    logic                      c_out_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      s_d;
    logic                      carry_d;

    full_adder_bit u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (s_d),
        .cout (carry_d)
    );

    // Control FSM and datapath: capture operands, shift one bit per cycle, pulse done
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= 2'd0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    a_q     <= A;
                    b_q     <= B;
                    carry_q <= C_in;
                    cnt_q   <= 2'd0;
                    sum_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    sum_q   <= {s_d, sum_q[FBSA_SUM_WIDTH-1:1]};
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        c_out_q <= carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sum   = sum_q;
    assign C_out = c_out_q;
    assign busy  = busy_q;
    assign done  = done_q;
endmodule
